vga_timing_gen: RTL

//  Video timing stage on the pixel_clk domain, downstream of the SDRAM/Wishbone pixel FIFO.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_hv_counter.sv | 55 +++++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 800x480 timing for the pixel-clock video stage.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_HDISP  = 800;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t BAR_COLOURS [8] = '{
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'h00, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'h00, 8'h00, 8'h00}
  };

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    return BAR_COLOURS[idx];
  endfunction

endpackage

// File: rtl/vga_hv_counter.sv
// Cascaded horizontal/vertical position counters with porch/sync/display region flags.
module vga_hv_counter
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP,
  localparam int HTOT  = HFP + HPULSE + HBP + HDISP,
  localparam int VTOT  = VFP + VPULSE + VBP + VDISP,
  localparam int HW    = $clog2(HTOT),
  localparam int VW    = $clog2(VTOT)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hdisp,
  output logic          vdisp,
  output logic          hsync,
  output logic          vsync
);

  localparam logic [HW-1:0] H_MAX      = HW'(HTOT - 1);
  localparam logic [HW-1:0] HS_START   = HW'(HFP);
  localparam logic [HW-1:0] HS_END     = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] HD_START   = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_MAX      = VW'(VTOT - 1);
  localparam logic [VW-1:0] VS_START   = VW'(VFP);
  localparam logic [VW-1:0] VS_END     = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] VD_START   = VW'(VFP + VPULSE + VBP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_MAX) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_MAX) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Region order on both axes: front porch, sync, back porch, display.
  assign hsync = (hcnt >= HS_START) && (hcnt < HS_END);
  assign hdisp = (hcnt >= HD_START);
  assign vsync = (vcnt >= VS_START) && (vcnt < VS_END);
  assign vdisp = (vcnt >= VD_START);

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing stage: HS/VS/DE generation, FIFO pixel pop and registered RGB with underflow flag.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic [23:0] pix_data,
  input  logic        pix_empty,
  output logic        pix_rd,
  input  logic        pattern_sel,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start,
  output logic        pix_underflow
);

  localparam int HTOT = HFP + HPULSE + HBP + HDISP;
  localparam int VTOT = VFP + VPULSE + VBP + VDISP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);

  logic [HW-1:0] hcnt_p0;
  logic [VW-1:0] vcnt_p0;
  logic          hdisp_p0;
  logic          vdisp_p0;
  logic          hsync_p0;
  logic          vsync_p0;
  logic          disp_p0;
  logic          pattern_active_p0;
  logic          underflow_p0;
  rgb_t          bar_rgb_p0;

  vga_hv_counter #(
    .HDISP  (HDISP),
    .HFP    (HFP),
    .HPULSE (HPULSE),
    .HBP    (HBP),
    .VDISP  (VDISP),
    .VFP    (VFP),
    .VPULSE (VPULSE),
    .VBP    (VBP)
  ) u_hv (
    .clk   (pixel_clk),
    .rst_n (pixel_rst_n),
    .hcnt  (hcnt_p0),
    .vcnt  (vcnt_p0),
    .hdisp (hdisp_p0),
    .vdisp (vdisp_p0),
    .hsync (hsync_p0),
    .vsync (vsync_p0)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int            BAR_W    = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  localparam logic [HW-1:0] BAR_W_V  = HW'(BAR_W);
  localparam logic [HW-1:0] HD_START = HW'(HFP + HPULSE + HBP);
  localparam logic [HW-1:0] LAST_BAR = HW'(7);

  logic [HW-1:0] xpos_p0;
  logic [HW-1:0] bar_full_p0;
  logic [2:0]    bar_idx_p0;

  assign pattern_active_p0 = pattern_sel;
  assign xpos_p0           = hcnt_p0 - HD_START;
  assign bar_full_p0       = xpos_p0 / BAR_W_V;
  // Leftover pixels when HDISP is not a multiple of 8 stay in the last bar.
  assign bar_idx_p0        = (bar_full_p0 > LAST_BAR) ? 3'd7 : bar_full_p0[2:0];
  assign bar_rgb_p0        = bar_colour(bar_idx_p0);
`else
  logic unused_pattern_sel;

  assign pattern_active_p0  = 1'b0;
  assign bar_rgb_p0         = '0;
  assign unused_pattern_sel = pattern_sel;
`endif

  assign disp_p0      = hdisp_p0 && vdisp_p0;
  // Gate with reset so the FIFO is never popped while the block is held in reset.
  assign pix_rd       = pixel_rst_n && disp_p0 && !pix_empty && !pattern_active_p0;
  assign underflow_p0 = disp_p0 && pix_empty && !pattern_active_p0;

  // ---- stage 1: registered video outputs ----
  logic        hs_p1;
  logic        vs_p1;
  logic        vld_p1;
  logic [23:0] rgb_p1;
  logic        fs_p1;
  logic        uf_p1;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      vld_p1 <= 1'b0;
      rgb_p1 <= '0;
      fs_p1  <= 1'b0;
      uf_p1  <= 1'b0;
    end else begin
      hs_p1  <= !hsync_p0;
      vs_p1  <= !vsync_p0;
      vld_p1 <= disp_p0;
      fs_p1  <= (hcnt_p0 == '0) && (vcnt_p0 == '0);
      if (pix_rd)
        rgb_p1 <= pix_data;
      else if (pattern_active_p0 && disp_p0)
        rgb_p1 <= bar_rgb_p0;
      else
        rgb_p1 <= '0;
      if (underflow_p0)
        uf_p1 <= 1'b1;
    end
  end

  assign video_hs      = hs_p1;
  assign video_vs      = vs_p1;
  assign video_de      = vld_p1;
  assign video_rgb     = rgb_p1;
  assign frame_start   = fs_p1;
  assign pix_underflow = uf_p1;

endmodule
